stg5wb: RTL

- Write-back stage; the consumer end of the stage-4 memory-operation latch bundle (pc, instr, opc, gp/sr targets with write enables, result).
- Owns the GP and SR register files and commits each retiring result into them.
- Serves combinational read ports to decode, with same-cycle write-through bypass.
- Keeps a retired-instruction counter, a last-retired PC and a sticky halt flag.

---
 rtl/stg5wb.sv | 66 ++++++
 1 files changed

// File: rtl/stg5wb.sv
// stg5wb: write-back stage owning GP/SR files with bypassed reads, retire pulse, last PC/instr, retire count, sticky halt
module stg5wb #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 24,
  parameter int OPC_W = 8,
  parameter int GP_W = 4,
  parameter int SR_W = 2,
  parameter logic [OPC_W-1:0] NOP_OPC = 8'h00,
  parameter logic [OPC_W-1:0] HALT_OPC = 8'hFF,
  parameter bit GP0_ZERO = 1'b1
) (
  input  logic              iw_clk,
  input  logic              iw_rst,
  input  logic [ADDR_W-1:0] iw_pc,
  input  logic [DATA_W-1:0] iw_instr,
  input  logic [OPC_W-1:0]  iw_opc,
  input  logic [GP_W-1:0]   iw_tgt_gp,
  input  logic              iw_tgt_gp_we,
  input  logic [SR_W-1:0]   iw_tgt_sr,
  input  logic              iw_tgt_sr_we,
  input  logic [DATA_W-1:0] iw_result,
  input  logic [GP_W-1:0]   iw_rd_gp_a,
  input  logic [GP_W-1:0]   iw_rd_gp_b,
  input  logic [SR_W-1:0]   iw_rd_sr,
  output logic [DATA_W-1:0] ow_gp_a,
  output logic [DATA_W-1:0] ow_gp_b,
  output logic [DATA_W-1:0] ow_sr,
  output logic              ow_retire,
  output logic [ADDR_W-1:0] ow_pc,
  output logic [DATA_W-1:0] ow_instr,
  output logic [31:0]       ow_retired,
  output logic              ow_halted
);
  logic [DATA_W-1:0] gp [2**GP_W];
  logic [DATA_W-1:0] sr [2**SR_W];
  logic active, retiring, gp_byp, sr_byp, gp_we;
  assign active = !ow_halted;
  assign retiring = active && (iw_opc != NOP_OPC);
  assign gp_byp = active && iw_tgt_gp_we;
  assign sr_byp = active && iw_tgt_sr_we;
  assign gp_we = gp_byp && !(GP0_ZERO && iw_tgt_gp == '0);
  assign ow_gp_a = (GP0_ZERO && iw_rd_gp_a == '0) ? '0 : (gp_byp && iw_rd_gp_a == iw_tgt_gp) ? iw_result : gp[iw_rd_gp_a];
  assign ow_gp_b = (GP0_ZERO && iw_rd_gp_b == '0) ? '0 : (gp_byp && iw_rd_gp_b == iw_tgt_gp) ? iw_result : gp[iw_rd_gp_b];
  assign ow_sr = (sr_byp && iw_rd_sr == iw_tgt_sr) ? iw_result : sr[iw_rd_sr];
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      for (int i = 0; i < 2**GP_W; i++) gp[i] <= '0;
      for (int i = 0; i < 2**SR_W; i++) sr[i] <= '0;
      ow_retire <= 1'b0;
      ow_pc <= '0;
      ow_instr <= '0;
      ow_retired <= '0;
      ow_halted <= 1'b0;
    end else begin
      if (gp_we) gp[iw_tgt_gp] <= iw_result;
      if (sr_byp) sr[iw_tgt_sr] <= iw_result;
      ow_retire <= retiring;
      if (retiring) begin
        ow_pc <= iw_pc;
        ow_instr <= iw_instr;
        ow_retired <= ow_retired + 32'd1;
      end
      if (retiring && iw_opc == HALT_OPC) ow_halted <= 1'b1;
    end
  end
endmodule
